// File: rtl/blur_strip_feeder_if.sv
// Bus bundle between the strip feeder, pixel memory and the blur controller.
interface blur_strip_feeder_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid;
  logic [7:0]        mem_rd_data;
  logic              anchor_moving;
  logic [31:0]       anchor_x;
  logic [31:0]       anchor_y;
  logic [19:0][7:0]  blur_in;
  logic              blur_final;

  modport master (
    output mem_rd_req, mem_addr, anchor_moving, anchor_x, anchor_y, blur_in,
    input  mem_rd_valid, mem_rd_data, blur_final
  );

  modport slave (
    input  mem_rd_req, mem_addr, anchor_moving, anchor_x, anchor_y, blur_in,
    output mem_rd_valid, mem_rd_data, blur_final
  );
endinterface

// File: rtl/blur_strip_feeder.sv
// Reads an image strip by strip, builds 20-pixel edge-replicated row segments
// in two ping-pong banks and hands them to the blur controller one row at a time.
module blur_strip_feeder #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  blur_strip_feeder_if.master bus
);
  localparam int SEG    = 20;
  localparam int LAST_K = IMG_H + 3;
  localparam int LAST_S = IMG_W - 16;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, STALL, DONE} state_t;
  state_t state;

  logic [1:0][SEG-1:0][7:0] bank, bank_nx;
  logic [1:0]  ready, ready_nx;
  logic        fb, pb;
  logic        fetch_on, outstanding;
  logic [4:0]  req_j, dat_j;
  logic [31:0] fk, fs, fk_next, fs_next;
  logic [31:0] pk, ps, pk_next, ps_next;
  logic        launch, accept, fill_done, req, release_row, last_row;

  function automatic logic [31:0] clamp(input logic signed [31:0] v, input int hi);
    if (v < 0) return 32'd0;
    if (v > hi) return 32'(hi);
    return $unsigned(v);
  endfunction

  // Row-major address of the pixel behind segment element j of padded row k, strip s.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [31:0] k, input logic [31:0] s,
                                                 input logic [4:0] j);
    logic [31:0] r, c;
    r = clamp($signed(k) - 32'sd2, IMG_H - 1);
    c = clamp($signed(s) + $signed({27'd0, j}) - 32'sd2, IMG_W - 1);
    return ADDR_W'(r * 32'(IMG_W) + c);
  endfunction

  assign launch      = (state == IDLE) && start;
  assign accept      = bus.mem_rd_valid && outstanding;
  assign fill_done   = accept && (dat_j == 5'(SEG - 1));
  assign req         = fetch_on && !ready[fb] && (req_j < 5'(SEG)) && (!outstanding || accept);
  assign release_row = (state == WAIT) && bus.blur_final;
  assign last_row    = (pk == 32'(LAST_K)) && (ps == 32'(LAST_S));

  assign bus.mem_rd_req = req;
  assign bus.mem_addr   = pix_addr(fk, fs, req_j);

  // Bank contents and ready flags as they will be after this edge, so a row can be
  // issued in the same cycle its last pixel arrives.
  always_comb begin
    bank_nx  = bank;
    ready_nx = ready;
    if (accept) bank_nx[fb][dat_j] = bus.mem_rd_data;
    if (fill_done) ready_nx[fb] = 1'b1;
    fk_next = (fk == 32'(LAST_K)) ? 32'd0 : fk + 32'd1;
    fs_next = (fk == 32'(LAST_K)) ? fs + 32'd16 : fs;
    pk_next = (pk == 32'(LAST_K)) ? 32'd0 : pk + 32'd1;
    ps_next = (pk == 32'(LAST_K)) ? ps + 32'd16 : ps;
  end

  // Bank storage: pure data, written only by returning reads.
  always_ff @(posedge clk) begin
    bank <= bank_nx;
  end

  // Fetch engine: fills bank fb with the next padded row whenever that bank is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_on    <= 1'b0;
      outstanding <= 1'b0;
      fb          <= 1'b0;
      req_j       <= '0;
      dat_j       <= '0;
      fk          <= '0;
      fs          <= '0;
      ready       <= '0;
    end else begin
      outstanding <= req | (outstanding & ~accept);
      ready       <= ready_nx & ~(release_row ? (2'b01 << pb) : 2'b00);
      if (launch) begin
        fetch_on <= 1'b1;
        fb       <= 1'b0;
        req_j    <= '0;
        dat_j    <= '0;
        fk       <= '0;
        fs       <= '0;
        ready    <= '0;
      end else begin
        if (req) req_j <= req_j + 5'd1;
        if (accept) dat_j <= dat_j + 5'd1;
        if (fill_done) begin
          req_j <= '0;
          dat_j <= '0;
          fb    <= ~fb;
          fk    <= fk_next;
          fs    <= fs_next;
          if ((fk == 32'(LAST_K)) && (fs == 32'(LAST_S))) fetch_on <= 1'b0;
        end
      end
    end
  end

  // Presentation FSM: issues each ready bank, waits for blur_final, then moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      pb                <= 1'b0;
      pk                <= '0;
      ps                <= '0;
      bus.anchor_moving <= 1'b0;
      bus.anchor_x      <= '0;
      bus.anchor_y      <= '0;
      bus.blur_in       <= '0;
    end else begin
      bus.anchor_moving <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            busy  <= 1'b1;
            pb    <= 1'b0;
            pk    <= '0;
            ps    <= '0;
          end
        end
        FILL, STALL: begin
          if (ready_nx[pb]) begin
            state             <= ISSUE;
            bus.anchor_moving <= 1'b1;
            bus.blur_in       <= bank_nx[pb];
            bus.anchor_x      <= pk;
            bus.anchor_y      <= ps;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.blur_final) begin
            if (last_row) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              pb <= ~pb;
              pk <= pk_next;
              ps <= ps_next;
              if (ready_nx[~pb]) begin
                state             <= ISSUE;
                bus.anchor_moving <= 1'b1;
                bus.blur_in       <= bank_nx[~pb];
                bus.anchor_x      <= pk_next;
                bus.anchor_y      <= ps_next;
              end else begin
                state <= STALL;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_strip_feeder.sv
// Scoreboard bench for blur_strip_feeder: reference segments are queued at pass
// start and a monitor compares every anchor_moving against them.
module tb_blur_strip_feeder;
  localparam int W  = 32;
  localparam int H  = 4;
  localparam int AW = 16;
  localparam int N  = W * H;
  localparam int HS = (W / 16) * (H + 4);

  logic clk = 1'b0;
  logic rst, start, busy, done;

  blur_strip_feeder_if #(.ADDR_W(AW)) bus();

  blur_strip_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int s;
    logic [159:0] seg;
  } exp_t;

  exp_t q[$];
  logic [7:0] mem [N];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, s0 = 0, req_cnt = 0, hs = 0, done_cnt = 0, final_cyc = 0;
  bit first_pending = 0, final_valid = 0, fast_chk = 0, ident = 0;
  bit ctl_en = 0, ctl_rand = 0, ctl_poke = 0;
  int ctl_d = 3;
  logic [159:0] last_seg = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [159:0] ref_seg(input int k, input int s);
    logic [159:0] r;
    for (int j = 0; j < 20; j++)
      r[j*8 +: 8] = mem[clampi(k - 2, H - 1) * W + clampi(s + j - 2, W - 1)];
    return r;
  endfunction

  // Pixel memory: one-cycle read latency, cleared together with the DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) bus.mem_rd_valid <= 1'b0;
    else begin
      bus.mem_rd_valid <= bus.mem_rd_req;
      bus.mem_rd_data  <= mem[int'(bus.mem_addr) % N];
    end
  end

  // Monitor: pops the scoreboard on every presented row.
  always @(negedge clk) begin
    exp_t e;
    logic [159:0] c;
    if (!rst) begin
      if (bus.anchor_moving) begin
        if (first_pending) begin
          check("first_latency", 160'(cyc - s0), 160'(21));
          check("reqs_before_first", 160'(req_cnt), 160'(20));
          first_pending = 0;
        end
        hs++;
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_handshake: got anchor (%0d,%0d) expected none", bus.anchor_x, bus.anchor_y);
        end else begin
          e = q.pop_front();
          check("anchor_x", 160'(bus.anchor_x), 160'(e.k));
          check("anchor_y", 160'(bus.anchor_y), 160'(e.s));
          check("blur_in", bus.blur_in, e.seg);
          if (ident && e.s == 0 && e.k == 0) begin
            for (int j = 0; j < 20; j++) c[j*8 +: 8] = 8'((j < 2) ? 0 : j - 2);
            check("seg_k0_s0", bus.blur_in, c);
          end
          if (ident && e.s == 16 && e.k == 3) begin
            for (int j = 0; j < 20; j++) c[j*8 +: 8] = 8'((j <= 17) ? 46 + j : 63);
            check("seg_k3_s16", bus.blur_in, c);
          end
          if (ident && e.s == 0 && e.k >= 6) begin
            for (int j = 0; j < 20; j++) c[j*8 +: 8] = 8'(96 + ((j < 2) ? 0 : j - 2));
            check("seg_bottom_repl", bus.blur_in, c);
          end
        end
        if (fast_chk && final_valid) check("row_to_row", 160'(cyc), 160'(final_cyc + 1));
        last_seg = bus.blur_in;
      end
      if (bus.mem_rd_req) req_cnt++;
      if (done) done_cnt++;
    end
  end

  // Controller model: answers each anchor_moving with blur_final after a delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (ctl_en && !rst && bus.anchor_moving) begin
        d = ctl_rand ? int'($urandom_range(1, 10)) : ctl_d;
        if (ctl_poke) begin
          bus.blur_final = 1'b1;
          @(posedge clk); #1 bus.blur_final = 1'b0;
          repeat (d - 1) @(posedge clk);
        end else begin
          repeat (d) @(posedge clk);
        end
        #1 bus.blur_final = 1'b1;
        final_cyc   = cyc;
        final_valid = 1;
        if (busy && !rst) check("blur_in_stable", bus.blur_in, last_seg);
        @(posedge clk); #1 bus.blur_final = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_done", 160'(done), 160'(0));
    check("rst_req", 160'(bus.mem_rd_req), 160'(0));
    check("rst_addr", 160'(bus.mem_addr), 160'(0));
    check("rst_moving", 160'(bus.anchor_moving), 160'(0));
    check("rst_ax", 160'(bus.anchor_x), 160'(0));
    check("rst_ay", 160'(bus.anchor_y), 160'(0));
    check("rst_blur_in", bus.blur_in, 160'(0));
  endtask

  task automatic begin_pass();
    q.delete();
    for (int s = 0; s < W; s += 16)
      for (int k = 0; k < H + 4; k++) q.push_back('{k: k, s: s, seg: ref_seg(k, s)});
    hs = 0; done_cnt = 0; final_valid = 0; req_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s0 = cyc; req_cnt = 0; first_pending = 1;
  endtask

  task automatic finish_pass(input bit inject_start);
    bit seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start = (inject_start && i == 30) ? 1'b1 : 1'b0;
      #1;
      if (done_cnt > 0) begin seen = 1; break; end
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL pass_timeout: got no done expected done within 5000 cycles");
    end
    repeat (5) @(negedge clk);
    check("done_count", 160'(done_cnt), 160'(1));
    check("handshakes", 160'(hs), 160'(HS));
    check("queue_empty", 160'(q.size()), 160'(0));
    check("busy_after_done", 160'(busy), 160'(0));
    check("hold_blur_in", bus.blur_in, ref_seg(H + 3, W - 16));
    check("hold_ax", 160'(bus.anchor_x), 160'(H + 3));
    check("hold_ay", 160'(bus.anchor_y), 160'(W - 16));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; bus.blur_final = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i % 256);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk); rst = 1'b0;

    // Identity image, controller answers 3 cycles after each row.
    ident = 1; ctl_en = 1; ctl_d = 3;
    begin_pass();
    finish_pass(0);

    // Late blur_final: prefetch must finish without disturbing the presented row.
    ctl_d = 40; fast_chk = 1;
    begin_pass();
    finish_pass(0);
    fast_chk = 0; ctl_d = 3;

    // Reset on the 5th handshake, then a fresh pass from (0,0).
    begin_pass();
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (hs >= 5) begin hit = 1; break; end
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL reach_5th: got %0d handshakes expected 5", hs);
    end
    rst = 1'b1;
    @(posedge clk); #1 check_reset_outputs();
    rst = 1'b0;
    first_pending = 0;
    repeat (6) @(negedge clk);
    begin_pass();
    finish_pass(0);

    // start while busy and blur_final during the ISSUE cycle are both ignored.
    ctl_poke = 1;
    begin_pass();
    finish_pass(1);
    ctl_poke = 0;

    // Random images with random controller delays.
    ident = 0; ctl_rand = 1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      begin_pass();
      finish_pass(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
